cpu_wb_ctrl: RTL and testbench
==============================

Name: cpu_wb_ctrl

Overview:
- Writeback controller that drives the general-register-file write port (rd_wen/rd_idx/rd_dat).
- Merges two result sources:
  - single-cycle ALU results, which always have priority;
  - long-latency LSU/MUL results, which use a valid/ready handshake and a small in-order FIFO.
- Keeps a scoreboard of registers awaiting a long-latency result; issue logic uses it for RAW hazard stalls.

Parameters:
- XLEN, 32, data width of register file.
- IDX_W, 5, register index width.
- GREG_COUNT, 32, number of general registers, equal to 2**IDX_W.
- FIFO_DEPTH, 2, LSU result buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- alu_valid  in  1  ALU result present this cycle, no backpressure.
- alu_rd_idx  in  IDX_W  ALU destination register.
- alu_dat  in  XLEN  ALU result.
- lsu_valid  in  1  long-latency result offered.
- lsu_ready  out  1  controller can accept the LSU result; equals FIFO not full.
- lsu_rd_idx  in  IDX_W  LSU destination register.
- lsu_dat  in  XLEN  LSU result.
- iss_valid  in  1  long-latency instruction issued this cycle.
- iss_rd_idx  in  IDX_W  its destination register.
- busy  out  GREG_COUNT  scoreboard; bit i=1 means xi has a pending long-latency write.
- rd_wen  out  1  register-file write enable (registered).
- rd_idx  out  IDX_W  register-file write index (registered).
- rd_dat  out  XLEN  register-file write data (registered).
- conflict_cnt  out  16  saturating count of cycles where an LSU result was buffered because of ALU priority.

Behaviour:
- Reset (async, high):
  - rd_wen=0, rd_idx=0, rd_dat=0;
  - busy=0, conflict_cnt=0;
  - FIFO emptied, so lsu_ready=1 after reset deasserts.
  - Reset mid-transfer discards buffered results and clears the scoreboard.
- LSU accept: an LSU result is accepted on a rising edge when lsu_valid and lsu_ready are both 1.
- Per-cycle selection of the write candidate, in priority order:
  1. alu_valid=1: write the ALU result. An accepted LSU result is pushed to the FIFO.
  2. otherwise FIFO non-empty: pop the head and write it. An accepted LSU result is pushed behind it, so order is preserved.
  3. otherwise FIFO empty and LSU accepted: write the LSU result directly, with no FIFO entry.
  4. otherwise rd_wen=0.
- Write latency: the selected candidate appears on rd_* one cycle later.
  - ALU latency is always 1.
  - LSU latency is 1 when uncontended, plus 1 per cycle spent queued.
- Index x0:
  - A candidate with idx 0 is consumed (popped or accepted) but produces rd_wen=0.
  - rd_idx and rd_dat still update.
- Push and pop in the same cycle: occupancy is unchanged and the pointers wrap modulo FIFO_DEPTH.
- FIFO full: lsu_ready=0. lsu_valid is ignored until a pop occurs. The source must hold lsu_valid and its data stable while lsu_ready=0.
- conflict_cnt increments when alu_valid=1 and an LSU result is accepted in the same cycle. It saturates at 16'hFFFF.
- Scoreboard:
  - Set: iss_valid with iss_rd_idx!=0 sets busy[iss_rd_idx] on the next edge.
  - Clear: busy[idx] clears when an LSU-originated candidate with that idx is written, i.e. on the edge on which rd_wen rises for it.
  - Set and clear of the same idx in the same cycle: set wins.
  - busy[0] is always 0.
  - ALU writes never touch busy.
- Ports are not checked for same-register conflicts; the issue stage must not send an ALU write to a busy register.
- rd_* are registered outputs and never depend combinationally on inputs. lsu_ready and busy come directly from state flops.

Test Plan:
- Reset then idle: assert reset mid-cycle with FIFO holding 1 entry and busy[5]=1 -> immediately rd_wen=0, busy=0, lsu_ready=1, conflict_cnt=0.
- ALU only: alu_valid, idx 3, dat 32'h1234 -> next cycle rd_wen=1, rd_idx=3, rd_dat=32'h1234. Same with idx 0 -> rd_wen=0.
- Uncontended LSU: iss_valid idx 7, busy[7]=1. Two cycles later lsu_valid idx 7, dat 32'hCAFE -> next cycle rd_wen=1, rd_idx=7, rd_dat=32'hCAFE, busy[7]=0 on the same edge.
- Contention and order: alu_valid held 3 cycles while LSU offers A(idx 8) then B(idx 9) ->
  - A and B are buffered and lsu_ready drops to 0 after 2 pushes;
  - conflict_cnt=2;
  - after the ALU stops, rd_* shows A then B in consecutive cycles;
  - the third LSU result C is accepted only after the first pop.
- Set/clear collision: LSU write to idx 4 completes on the same edge a new iss_valid idx 4 arrives -> busy[4] stays 1.
- Saturation: force 65540 conflict cycles -> conflict_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/cpu_wb_ctrl.sv
// Writeback controller: merges single-cycle ALU results with buffered long-latency results
// onto the register-file write port, and tracks pending long-latency destinations.
`timescale 1ns/1ps
module cpu_wb_ctrl #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned IDX_W      = 5,
    parameter int unsigned GREG_COUNT = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [IDX_W-1:0]      alu_rd_idx,
    input  logic [XLEN-1:0]       alu_dat,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [IDX_W-1:0]      lsu_rd_idx,
    input  logic [XLEN-1:0]       lsu_dat,
    input  logic                  iss_valid,
    input  logic [IDX_W-1:0]      iss_rd_idx,
    output logic [GREG_COUNT-1:0] busy,
    output logic                  rd_wen,
    output logic [IDX_W-1:0]      rd_idx,
    output logic [XLEN-1:0]       rd_dat,
    output logic [15:0]           conflict_cnt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] fifo_idx [FIFO_DEPTH];
    logic [XLEN-1:0]  fifo_dat [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    logic             accept;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             cand_valid;
    logic             cand_lsu;
    logic [IDX_W-1:0] cand_idx;
    logic [XLEN-1:0]  cand_dat;

    logic [GREG_COUNT-1:0] busy_next;
    logic [15:0]           conflict_next;

    assign accept     = lsu_valid & lsu_ready;
    assign fifo_empty = (count == '0);

    // Candidate selection: ALU first, then queued LSU results, then a direct LSU bypass.
    always_comb begin
        cand_valid = 1'b0;
        cand_lsu   = 1'b0;
        cand_idx   = '0;
        cand_dat   = '0;
        push       = 1'b0;
        pop        = 1'b0;
        if (alu_valid) begin
            cand_valid = 1'b1;
            cand_idx   = alu_rd_idx;
            cand_dat   = alu_dat;
            push       = accept;
        end else if (!fifo_empty) begin
            cand_valid = 1'b1;
            cand_lsu   = 1'b1;
            cand_idx   = fifo_idx[rd_ptr];
            cand_dat   = fifo_dat[rd_ptr];
            pop        = 1'b1;
            push       = accept;
        end else if (accept) begin
            cand_valid = 1'b1;
            cand_lsu   = 1'b1;
            cand_idx   = lsu_rd_idx;
            cand_dat   = lsu_dat;
        end
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Set wins over clear when the same register is re-issued as its result retires.
    always_comb begin
        busy_next = busy;
        if (cand_lsu) begin
            busy_next[cand_idx] = 1'b0;
        end
        if (iss_valid && (iss_rd_idx != '0)) begin
            busy_next[iss_rd_idx] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_comb begin
        conflict_next = conflict_cnt;
        if (alu_valid && accept && (conflict_cnt != 16'hFFFF)) begin
            conflict_next = conflict_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            lsu_ready    <= 1'b1;
            busy         <= '0;
            conflict_cnt <= '0;
            rd_wen       <= 1'b0;
            rd_idx       <= '0;
            rd_dat       <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count        <= count_next;
            lsu_ready    <= (count_next != CNT_W'(FIFO_DEPTH));
            busy         <= busy_next;
            conflict_cnt <= conflict_next;
            // x0 candidates are consumed and still update idx/dat, but never write.
            rd_wen       <= cand_valid && (cand_idx != '0);
            if (cand_valid) begin
                rd_idx <= cand_idx;
                rd_dat <= cand_dat;
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[wr_ptr] <= lsu_rd_idx;
            fifo_dat[wr_ptr] <= lsu_dat;
        end
    end

endmodule

// File: tb/tb_cpu_wb_ctrl.sv
// Directed self-checking bench for cpu_wb_ctrl; a second deep-FIFO instance exercises
// conflict counter saturation.
`timescale 1ns/1ps
module tb_cpu_wb_ctrl;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd_idx;
    logic [31:0] alu_dat;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd_idx;
    logic [31:0] lsu_dat;
    logic        iss_valid;
    logic [4:0]  iss_rd_idx;
    logic [31:0] busy;
    logic        rd_wen;
    logic [4:0]  rd_idx;
    logic [31:0] rd_dat;
    logic [15:0] conflict_cnt;

    logic        s_alu_valid;
    logic        s_lsu_valid;
    logic        s_lsu_ready;
    logic [31:0] s_busy;
    logic        s_rd_wen;
    logic [4:0]  s_rd_idx;
    logic [31:0] s_rd_dat;
    logic [15:0] s_conflict_cnt;

    int n_checks;
    int n_fail;

    cpu_wb_ctrl u_dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_rd_idx   (alu_rd_idx),
        .alu_dat      (alu_dat),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd_idx   (lsu_rd_idx),
        .lsu_dat      (lsu_dat),
        .iss_valid    (iss_valid),
        .iss_rd_idx   (iss_rd_idx),
        .busy         (busy),
        .rd_wen       (rd_wen),
        .rd_idx       (rd_idx),
        .rd_dat       (rd_dat),
        .conflict_cnt (conflict_cnt)
    );

    cpu_wb_ctrl #(.FIFO_DEPTH(65536)) u_sat (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (s_alu_valid),
        .alu_rd_idx   (5'd1),
        .alu_dat      (32'h0),
        .lsu_valid    (s_lsu_valid),
        .lsu_ready    (s_lsu_ready),
        .lsu_rd_idx   (5'd2),
        .lsu_dat      (32'h0),
        .iss_valid    (1'b0),
        .iss_rd_idx   (5'd0),
        .busy         (s_busy),
        .rd_wen       (s_rd_wen),
        .rd_idx       (s_rd_idx),
        .rd_dat       (s_rd_dat),
        .conflict_cnt (s_conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid  = 1'b0;
        alu_rd_idx = '0;
        alu_dat    = '0;
        lsu_valid  = 1'b0;
        lsu_rd_idx = '0;
        lsu_dat    = '0;
        iss_valid  = 1'b0;
        iss_rd_idx = '0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        s_alu_valid = 1'b0;
        s_lsu_valid = 1'b0;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_wen", rd_wen, 0);
        check("rst_idx", rd_idx, 0);
        check("rst_dat", rd_dat, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", lsu_ready, 1);
        check("rst_cnt", conflict_cnt, 0);

        // One buffered entry plus busy[5], then reset mid-cycle.
        iss_valid = 1'b1; iss_rd_idx = 5'd5;
        alu_valid = 1'b1; alu_rd_idx = 5'd1; alu_dat = 32'h11;
        lsu_valid = 1'b1; lsu_rd_idx = 5'd6; lsu_dat = 32'h66;
        tick();
        idle_inputs();
        check("pre_busy", busy, 32'h20);
        check("pre_cnt", conflict_cnt, 1);
        check("pre_wen", rd_wen, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_wen", rd_wen, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", lsu_ready, 1);
        check("mid_rst_cnt", conflict_cnt, 0);
        #1;
        reset = 1'b0;
        tick();
        check("post_rst_no_pop", rd_wen, 0);

        // ALU only
        alu_valid = 1'b1; alu_rd_idx = 5'd3; alu_dat = 32'h1234;
        tick();
        check("alu_wen", rd_wen, 1);
        check("alu_idx", rd_idx, 3);
        check("alu_dat", rd_dat, 32'h1234);
        alu_rd_idx = 5'd0; alu_dat = 32'h55;
        tick();
        check("alu_x0_wen", rd_wen, 0);
        check("alu_x0_idx", rd_idx, 0);
        check("alu_x0_dat", rd_dat, 32'h55);
        idle_inputs();

        // Uncontended LSU
        iss_valid = 1'b1; iss_rd_idx = 5'd7;
        tick();
        idle_inputs();
        check("iss_busy7", busy, 32'h80);
        tick();
        lsu_valid = 1'b1; lsu_rd_idx = 5'd7; lsu_dat = 32'hCAFE;
        tick();
        idle_inputs();
        check("lsu_wen", rd_wen, 1);
        check("lsu_idx", rd_idx, 7);
        check("lsu_dat", rd_dat, 32'hCAFE);
        check("lsu_busy_clr", busy, 0);
        tick();
        check("lsu_idle", rd_wen, 0);

        // Contention and order
        alu_valid = 1'b1; alu_rd_idx = 5'd10; alu_dat = 32'hA10;
        lsu_valid = 1'b1; lsu_rd_idx = 5'd8;  lsu_dat = 32'hAAAA;
        tick();
        check("c1_idx", rd_idx, 10);
        check("c1_ready", lsu_ready, 1);
        alu_rd_idx = 5'd11; alu_dat = 32'hA11;
        lsu_rd_idx = 5'd9;  lsu_dat = 32'hBBBB;
        tick();
        check("c2_idx", rd_idx, 11);
        check("c2_ready_full", lsu_ready, 0);
        check("c2_cnt", conflict_cnt, 2);
        alu_rd_idx = 5'd12; alu_dat = 32'hA12;
        lsu_rd_idx = 5'd13; lsu_dat = 32'hCCCC;
        tick();
        check("c3_idx", rd_idx, 12);
        check("c3_ready", lsu_ready, 0);
        check("c3_cnt", conflict_cnt, 2);
        alu_valid = 1'b0;
        tick();
        check("pop_a_wen", rd_wen, 1);
        check("pop_a_idx", rd_idx, 8);
        check("pop_a_dat", rd_dat, 32'hAAAA);
        check("pop_a_ready", lsu_ready, 1);
        tick();
        lsu_valid = 1'b0;
        check("pop_b_idx", rd_idx, 9);
        check("pop_b_dat", rd_dat, 32'hBBBB);
        tick();
        check("pop_c_wen", rd_wen, 1);
        check("pop_c_idx", rd_idx, 13);
        check("pop_c_dat", rd_dat, 32'hCCCC);
        check("after_cnt", conflict_cnt, 2);
        tick();
        check("drained", rd_wen, 0);
        idle_inputs();

        // Set/clear collision on x4; x0 never marked busy
        iss_valid = 1'b1; iss_rd_idx = 5'd4;
        tick();
        check("iss_busy4", busy, 32'h10);
        lsu_valid = 1'b1; lsu_rd_idx = 5'd4; lsu_dat = 32'h44;
        tick();
        idle_inputs();
        check("coll_wen", rd_wen, 1);
        check("coll_idx", rd_idx, 4);
        check("coll_busy", busy, 32'h10);
        iss_valid = 1'b1; iss_rd_idx = 5'd0;
        lsu_valid = 1'b1; lsu_rd_idx = 5'd0; lsu_dat = 32'h99;
        tick();
        idle_inputs();
        check("x0_lsu_wen", rd_wen, 0);
        check("x0_lsu_dat", rd_dat, 32'h99);
        check("x0_busy", busy, 32'h10);

        // Saturation: deep FIFO accepts every cycle while the ALU holds priority.
        s_alu_valid = 1'b1;
        s_lsu_valid = 1'b1;
        repeat (65540) tick();
        check("sat_cnt", s_conflict_cnt, 16'hFFFF);
        check("sat_ready", s_lsu_ready, 0);
        tick();
        check("sat_hold", s_conflict_cnt, 16'hFFFF);
        s_alu_valid = 1'b0;
        s_lsu_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
